// File: rtl/int_issue_port_arbiter.sv
// Round-robin integer issue-port arbiter with replay window, stall, clear and selective flush.
// Optional performance counters are enabled by defining INT_ISSUE_ARB_PERF_EN.
module int_issue_port_arbiter #(
  parameter int NUM_ENTRIES = 16,
  parameter int ISSUE_WIDTH = 2,
  parameter int REPLAY_LAT  = 2,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         clear,
  input  logic [NUM_ENTRIES-1:0]       req,
  input  logic [NUM_ENTRIES-1:0]       flush,
  input  logic                         replay,
  output logic [ISSUE_WIDTH-1:0]       grantValid,
  output logic [ISSUE_WIDTH*IDX_W-1:0] grantPtr,
`ifdef INT_ISSUE_ARB_PERF_EN
  output logic [31:0]                  perfGrantCount,
  output logic [31:0]                  perfReplayCycles,
`endif
  output logic                         busy
);

  localparam int CNT_W = (REPLAY_LAT > 1) ? $clog2(REPLAY_LAT) : 1;

  typedef enum logic [0:0] {
    ST_ISSUE  = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  state_t                         state_r;
  logic [CNT_W-1:0]               cnt_r;
  logic [IDX_W-1:0]               rr_ptr_r;
  logic [NUM_ENTRIES-1:0]         last_mask_r;
  logic [ISSUE_WIDTH-1:0]         grant_valid_r;
  logic [ISSUE_WIDTH*IDX_W-1:0]   grant_ptr_r;
  logic                           busy_r;

  logic [NUM_ENTRIES-1:0]         eligible_s;
  logic [ISSUE_WIDTH-1:0]         sel_valid_s;
  logic [ISSUE_WIDTH*IDX_W-1:0]   sel_ptr_s;
  logic [NUM_ENTRIES-1:0]         sel_mask_s;
  logic [IDX_W-1:0]               last_idx_s;
  logic [IDX_W-1:0]               next_rr_s;
  logic [ISSUE_WIDTH-1:0]         hold_valid_s;

  assign eligible_s = req & ~flush & ~last_mask_r;

  // Round-robin scan from rr_ptr_r: k-th eligible entry binds to port k.
  always_comb begin
    int k;
    int idx;
    k           = 0;
    idx         = 0;
    sel_valid_s = {ISSUE_WIDTH{1'b0}};
    sel_ptr_s   = {(ISSUE_WIDTH*IDX_W){1'b0}};
    sel_mask_s  = {NUM_ENTRIES{1'b0}};
    last_idx_s  = rr_ptr_r;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= NUM_ENTRIES) begin
        idx = idx - NUM_ENTRIES;
      end else begin
        idx = idx;
      end
      if (eligible_s[idx] && (k < ISSUE_WIDTH)) begin
        sel_valid_s[k]                 = 1'b1;
        sel_ptr_s[k*IDX_W +: IDX_W]    = IDX_W'(idx);
        sel_mask_s[idx]                = 1'b1;
        last_idx_s                     = IDX_W'(idx);
        k                              = k + 1;
      end else begin
        k = k;
      end
    end
  end

  // Pointer advances to one past the last granted entry, wrapping at NUM_ENTRIES-1.
  always_comb begin
    if (last_idx_s == IDX_W'(NUM_ENTRIES - 1)) begin
      next_rr_s = {IDX_W{1'b0}};
    end else begin
      next_rr_s = last_idx_s + IDX_W'(1);
    end
  end

  // While stalled, a held grant is dropped if its entry gets flushed.
  always_comb begin
    hold_valid_s = {ISSUE_WIDTH{1'b0}};
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      hold_valid_s[p] = grant_valid_r[p] & ~flush[grant_ptr_r[p*IDX_W +: IDX_W]];
    end
  end

  // Arbitration state, FSM and registered grant outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_ISSUE;
      cnt_r         <= {CNT_W{1'b0}};
      rr_ptr_r      <= {IDX_W{1'b0}};
      last_mask_r   <= {NUM_ENTRIES{1'b0}};
      grant_valid_r <= {ISSUE_WIDTH{1'b0}};
      grant_ptr_r   <= {(ISSUE_WIDTH*IDX_W){1'b0}};
      busy_r        <= 1'b0;
    end else if (clear) begin
      state_r       <= ST_ISSUE;
      cnt_r         <= {CNT_W{1'b0}};
      last_mask_r   <= {NUM_ENTRIES{1'b0}};
      grant_valid_r <= {ISSUE_WIDTH{1'b0}};
      grant_ptr_r   <= {(ISSUE_WIDTH*IDX_W){1'b0}};
      busy_r        <= 1'b0;
    end else if (replay) begin
      // Enters REPLAY from ISSUE (stalled or not) and reloads the window inside REPLAY.
      state_r       <= ST_REPLAY;
      cnt_r         <= CNT_W'(REPLAY_LAT - 1);
      last_mask_r   <= {NUM_ENTRIES{1'b0}};
      grant_valid_r <= {ISSUE_WIDTH{1'b0}};
      grant_ptr_r   <= {(ISSUE_WIDTH*IDX_W){1'b0}};
      busy_r        <= 1'b1;
    end else if (stall) begin
      grant_valid_r <= hold_valid_s;
      if ((state_r == ST_REPLAY) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else if ((state_r == ST_REPLAY) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r         <= cnt_r - CNT_W'(1);
      last_mask_r   <= {NUM_ENTRIES{1'b0}};
      grant_valid_r <= {ISSUE_WIDTH{1'b0}};
      grant_ptr_r   <= {(ISSUE_WIDTH*IDX_W){1'b0}};
      busy_r        <= 1'b1;
    end else begin
      // Normal issue; the final REPLAY cycle also issues so ports stay blocked exactly REPLAY_LAT cycles.
      state_r       <= ST_ISSUE;
      busy_r        <= 1'b0;
      grant_valid_r <= sel_valid_s;
      grant_ptr_r   <= sel_ptr_s;
      last_mask_r   <= sel_mask_s;
      if (|sel_valid_s) begin
        rr_ptr_r <= next_rr_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign grantValid = grant_valid_r;
  assign grantPtr   = grant_ptr_r;
  assign busy       = busy_r;

`ifdef INT_ISSUE_ARB_PERF_EN
  logic [31:0] perf_grant_cnt_r;
  logic [31:0] perf_replay_cnt_r;

  function automatic logic [31:0] count_ones(input logic [ISSUE_WIDTH-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Performance counters freeze while the issue stage is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant_cnt_r  <= 32'd0;
      perf_replay_cnt_r <= 32'd0;
    end else if (!stall) begin
      perf_grant_cnt_r <= perf_grant_cnt_r + count_ones(grant_valid_r);
      if (state_r == ST_REPLAY) begin
        perf_replay_cnt_r <= perf_replay_cnt_r + 32'd1;
      end else begin
        perf_replay_cnt_r <= perf_replay_cnt_r;
      end
    end else begin
      perf_grant_cnt_r  <= perf_grant_cnt_r;
      perf_replay_cnt_r <= perf_replay_cnt_r;
    end
  end

  assign perfGrantCount   = perf_grant_cnt_r;
  assign perfReplayCycles = perf_replay_cnt_r;
`endif

endmodule

// File: tb/tb_int_issue_port_arbiter.sv
// Directed bench for int_issue_port_arbiter (default parameters: 16 entries, 2 ports, replay latency 2).
module tb_int_issue_port_arbiter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        clear;
  logic [15:0] req;
  logic [15:0] flush;
  logic        replay;
  logic [1:0]  grantValid;
  logic [7:0]  grantPtr;
  logic        busy;
`ifdef INT_ISSUE_ARB_PERF_EN
  logic [31:0] perfGrantCount;
  logic [31:0] perfReplayCycles;
`endif

  int errors = 0;
  int checks = 0;

  int_issue_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .clear      (clear),
    .req        (req),
    .flush      (flush),
    .replay     (replay),
    .grantValid (grantValid),
    .grantPtr   (grantPtr),
`ifdef INT_ISSUE_ARB_PERF_EN
    .perfGrantCount   (perfGrantCount),
    .perfReplayCycles (perfReplayCycles),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] v, input logic [3:0] p0, input logic [3:0] p1);
    check({tag, "_valid"}, {30'd0, grantValid}, {30'd0, v});
    check({tag, "_p0"},    {28'd0, grantPtr[3:0]}, {28'd0, p0});
    check({tag, "_p1"},    {28'd0, grantPtr[7:4]}, {28'd0, p1});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; clear = 1'b0; req = 16'h0000; flush = 16'h0000; replay = 1'b0;
    #12;
    chk_grant("reset", 2'b00, 4'd0, 4'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
`ifdef INT_ISSUE_ARB_PERF_EN
    check("reset_perf_grant", perfGrantCount, 32'd0);
    check("reset_perf_replay", perfReplayCycles, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // rrPtr=0: entries 0 and 4 granted, rrPtr -> 5
    req = 16'h0011; tick();
    chk_grant("basic", 2'b11, 4'd0, 4'd4);
    // idle cycle clears lastMask, rrPtr stays 5
    req = 16'h0000; tick();
    chk_grant("idle", 2'b00, 4'd0, 4'd0);
    // only entry 13 -> rrPtr becomes 14
    req = 16'h2000; tick();
    chk_grant("single13", 2'b01, 4'd13, 4'd0);
    // wrap: 15 then 0, rrPtr -> 1
    req = 16'h8003; tick();
    chk_grant("wrap", 2'b11, 4'd15, 4'd0);

    // lastMask blocks back-to-back double grant
    req = 16'h0006; tick();
    chk_grant("lm_c1", 2'b11, 4'd1, 4'd2);
    tick();
    chk_grant("lm_c2", 2'b00, 4'd0, 4'd0);
    tick();
    chk_grant("lm_c3", 2'b11, 4'd1, 4'd2);

    // replay window of two cycles, grants resume on third
    req = 16'h0000; replay = 1'b1; tick();
    chk_grant("rp_c1", 2'b00, 4'd0, 4'd0);
    check("rp_c1_busy", {31'd0, busy}, 32'd1);
    replay = 1'b0; req = 16'h0030; tick();
    chk_grant("rp_c2", 2'b00, 4'd0, 4'd0);
    check("rp_c2_busy", {31'd0, busy}, 32'd1);
    tick();
    chk_grant("rp_c3", 2'b11, 4'd4, 4'd5);
    check("rp_c3_busy", {31'd0, busy}, 32'd0);

    // set up port0=3, port1=4 (rrPtr -> 5)
    req = 16'h0000; tick();
    chk_grant("idle2", 2'b00, 4'd0, 4'd0);
    req = 16'h0018; tick();
    chk_grant("pre_stall", 2'b11, 4'd3, 4'd4);
    // stall with flush of entry 3: only port0 drops
    stall = 1'b1; req = 16'hFFFF; flush = 16'h0008; tick();
    chk_grant("stall_flush", 2'b10, 4'd3, 4'd4);
    flush = 16'h0000; tick();
    chk_grant("stall_hold", 2'b10, 4'd3, 4'd4);
    // clear beats stall
    clear = 1'b1; tick();
    check("clear_valid", {30'd0, grantValid}, 32'd0);
    // rrPtr held at 5 through stall and clear
    clear = 1'b0; stall = 1'b0; req = 16'h0021; tick();
    chk_grant("post_clear", 2'b11, 4'd5, 4'd0);
    // same-cycle req and flush on entry 6: skipped; rrPtr was 1 so 6 then 7 scanned
    req = 16'h00C0; flush = 16'h0040; tick();
    chk_grant("req_flush", 2'b01, 4'd7, 4'd0);
    flush = 16'h0000;

    // replay together with stall enters REPLAY
    stall = 1'b1; replay = 1'b1; req = 16'hFFFF; tick();
    chk_grant("rp_stall", 2'b00, 4'd0, 4'd0);
    check("rp_stall_busy", {31'd0, busy}, 32'd1);
    replay = 1'b0; tick();
    check("rp_stall2_busy", {31'd0, busy}, 32'd1);

    // async reset mid-REPLAY, no clock edge
    #1 rst = 1'b0;
    #1;
    chk_grant("async_rst", 2'b00, 4'd0, 4'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
`ifdef INT_ISSUE_ARB_PERF_EN
    check("async_perf_grant", perfGrantCount, 32'd0);
    check("async_perf_replay", perfReplayCycles, 32'd0);
`endif
    stall = 1'b0; req = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    req = 16'h0002; tick();
    chk_grant("after_rst", 2'b01, 4'd1, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
